fetch_unit: RTL and testbench

Parametrised instruction-fetch sequencer; next generation of the core's FETCH/DECODE stage.
- Owns the PC and issues byte-addressed requests to instruction memory over a req/gnt + rvalid handshake that tolerates variable latency.
- Presents each fetched word to the decoder over a valid/ready handshake.
- Supports redirect (branch/jump) with discard of in-flight responses, halt with drain, and a delivered-instruction counter.

---
 rtl/fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch sequencer with redirect, halt/drain and delivery counter
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   o_mem_req/i_mem_gnt/o_mem_addr instruction memory request (byte address = pc[AW-1:0])
//   i_mem_rvalid/i_mem_rdata       in-order response, one per granted request
//   o_insn_valid/i_insn_ready      decoder handshake; o_insn, o_insn_pc held while valid
//   i_redirect/i_redirect_pc       one-cycle PC load, target aligned to INSN_BYTES
//   i_halt/o_halted                sticky stop; o_halted once nothing is outstanding
//   o_count                        instructions accepted by the decoder
module fetch_unit #(
  parameter int              XLEN       = 64,
  parameter int              AW         = 14,
  parameter int              IW         = 32,
  parameter int              INSN_BYTES = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic             o_mem_req,
  input  logic             i_mem_gnt,
  output logic [AW-1:0]    o_mem_addr,
  input  logic             i_mem_rvalid,
  input  logic [IW-1:0]    i_mem_rdata,
  output logic             o_insn_valid,
  input  logic             i_insn_ready,
  output logic [IW-1:0]    o_insn,
  output logic [XLEN-1:0]  o_insn_pc,
  input  logic             i_redirect,
  input  logic [XLEN-1:0]  i_redirect_pc,
  input  logic             i_halt,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_count
);

  typedef enum logic [2:0] {
    S_REQ    = 3'd0,
    S_WAIT   = 3'd1,
    S_HOLD   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSN_BYTES - 1));
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSN_BYTES);

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] fetch_pc;
  logic            discard, discard_n;
  logic            grant;    // request accepted this cycle: capture the fetch address
  logic            deliver;  // response latched into the decoder-facing registers
  logic            take;     // decoder handshake that counts
  logic            drop;     // held instruction withdrawn (redirect/halt)
  logic [XLEN-1:0] target;

  assign target     = i_redirect_pc & ALIGN_MASK;
  // State resets to REQ, so the request is gated while reset is asserted.
  assign o_mem_req  = (state == S_REQ) && i_rst_n;
  assign o_mem_addr = pc[AW-1:0];
  assign o_halted   = (state == S_HALTED);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_REQ;
    else          state <= state_n;
  end

  // Halt outranks redirect, redirect outranks normal progress.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    discard_n = discard;
    grant     = 1'b0;
    deliver   = 1'b0;
    take      = 1'b0;
    drop      = 1'b0;
    case (state)
      S_REQ: begin
        grant = i_mem_gnt;
        if (i_mem_gnt) pc_n = pc + PC_STEP;
        if (i_halt) begin
          state_n = i_mem_gnt ? S_DRAIN : S_HALTED;
        end else if (i_redirect) begin
          pc_n = target;
          if (i_mem_gnt) begin
            // Request already left; its response must be thrown away.
            discard_n = 1'b1;
            state_n   = S_WAIT;
          end
        end else if (i_mem_gnt) begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_halt) begin
          state_n = i_mem_rvalid ? S_HALTED : S_DRAIN;
        end else if (i_redirect) begin
          pc_n = target;
          if (i_mem_rvalid) begin
            discard_n = 1'b0;
            state_n   = S_REQ;
          end else begin
            discard_n = 1'b1;
          end
        end else if (i_mem_rvalid) begin
          if (discard) begin
            discard_n = 1'b0;
            state_n   = S_REQ;
          end else begin
            deliver = 1'b1;
            state_n = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (i_halt) begin
          drop    = 1'b1;
          state_n = S_HALTED;
        end else if (i_redirect) begin
          pc_n    = target;
          drop    = 1'b1;
          state_n = S_REQ;
        end else if (i_insn_ready) begin
          take    = 1'b1;
          state_n = S_REQ;
        end
      end
      S_DRAIN: begin
        if (i_mem_rvalid) begin
          discard_n = 1'b0;
          state_n   = S_HALTED;
        end
      end
      S_HALTED: begin
        state_n = S_HALTED;
      end
      default: begin
        state_n = S_REQ;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc           <= RESET_PC;
      fetch_pc     <= '0;
      discard      <= 1'b0;
      o_insn_valid <= 1'b0;
      o_insn       <= '0;
      o_insn_pc    <= '0;
      o_count      <= '0;
    end else begin
      pc      <= pc_n;
      discard <= discard_n;
      if (grant) fetch_pc <= pc;
      if (deliver) begin
        o_insn       <= i_mem_rdata;
        o_insn_pc    <= fetch_pc;
        o_insn_valid <= 1'b1;
      end else if (take || drop) begin
        o_insn_valid <= 1'b0;
      end
      if (take) o_count <= o_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [13:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        insn_valid, insn_ready;
  logic [31:0] insn;
  logic [63:0] insn_pc;
  logic        redirect, halt, halted;
  logic [63:0] redirect_pc;
  logic [31:0] count;

  logic        mem_req_b, mem_gnt_b, mem_rvalid_b;
  logic [13:0] mem_addr_b;
  logic [31:0] mem_rdata_b;
  logic        insn_valid_b, insn_ready_b;
  logic [31:0] insn_b;
  logic [15:0] insn_pc_b;
  logic        redirect_b, halt_b, halted_b;
  logic [15:0] redirect_pc_b;
  logic [31:0] count_b;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(64), .AW(14), .IW(32), .INSN_BYTES(4), .RESET_PC(64'h100), .CNT_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_mem_req(mem_req), .i_mem_gnt(mem_gnt), .o_mem_addr(mem_addr),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_insn_valid(insn_valid), .i_insn_ready(insn_ready), .o_insn(insn), .o_insn_pc(insn_pc),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc), .i_halt(halt), .o_halted(halted),
    .o_count(count));

  fetch_unit #(.XLEN(16), .AW(14), .IW(32), .INSN_BYTES(4), .RESET_PC(16'hFFFC), .CNT_W(32)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_mem_req(mem_req_b), .i_mem_gnt(mem_gnt_b), .o_mem_addr(mem_addr_b),
    .i_mem_rvalid(mem_rvalid_b), .i_mem_rdata(mem_rdata_b),
    .o_insn_valid(insn_valid_b), .i_insn_ready(insn_ready_b), .o_insn(insn_b), .o_insn_pc(insn_pc_b),
    .i_redirect(redirect_b), .i_redirect_pc(redirect_pc_b), .i_halt(halt_b), .o_halted(halted_b),
    .o_count(count_b));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the next instruction the decoder should see, and how many it has taken.
  logic [63:0] exp_pc;
  int unsigned exp_cnt;
  bit          halting;
  // Memory model: at most one pending response with a countdown.
  bit          pend;
  int          pend_wait;
  logic [13:0] pend_addr;
  // Stimulus policy.
  int          lat, gnt_pct, rdy_pct, redir_pct;
  bit          lat_rand;
  bit          force_redir, force_rdy, force_halt;
  logic [63:0] force_tgt;
  // Observation bookkeeping.
  int          gcount, dcount;
  logic [13:0] last_gaddr;
  logic [63:0] last_dpc;
  logic [13:0] gq[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [13:0] a);
    return ({18'd0, a} * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Called at a negedge: check what the DUT shows, then choose inputs for the next edge.
  task automatic decide();
    check("count", count, 64'(exp_cnt));
    if (mem_req) check("single_outstanding", 64'(pend), 64'd0);
    if (halting) check("halt_no_valid", insn_valid, 1'b0);
    if (pend && pend_wait == 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(pend_addr);
      pend       = 1'b0;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (pend) pend_wait--;
    end
    redirect    = force_redir || ($urandom_range(99) < redir_pct);
    redirect_pc = force_redir ? force_tgt : {$urandom, $urandom};
    halt        = force_halt;
    insn_ready  = force_rdy || ($urandom_range(99) < rdy_pct);
    mem_gnt     = mem_req && ($urandom_range(99) < gnt_pct);
    if (mem_gnt) begin
      check("req_addr", mem_addr, exp_pc[13:0]);
      pend       = 1'b1;
      pend_addr  = mem_addr;
      pend_wait  = lat_rand ? int'($urandom_range(3)) : lat - 1;
      last_gaddr = mem_addr;
      gq.push_back(mem_addr);
      gcount++;
    end
    if (insn_valid && insn_ready && !redirect && !halt && !halting) begin
      check("insn_pc", insn_pc, exp_pc);
      check("insn", insn, mem_word(exp_pc[13:0]));
      last_dpc = insn_pc;
      dcount++;
      exp_pc  = exp_pc + 64'd4;
      exp_cnt++;
    end
    if (redirect && !halt && !halting) exp_pc = redirect_pc & ~64'h3;
    if (halt) halting = 1'b1;
    force_redir = 1'b0;
    force_rdy   = 1'b0;
    force_halt  = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    decide();
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    int g0 = gcount;
    while (gcount == g0 && n < 100) begin step(); n++; end
    check(tag, 64'(n < 100), 64'd1);
  endtask

  task automatic wait_deliver(input string tag);
    int n = 0;
    int d0 = dcount;
    while (dcount == d0 && n < 100) begin step(); n++; end
    check(tag, 64'(n < 100), 64'd1);
  endtask

  // Leaves the bench at a negedge where the condition holds, before decide().
  task automatic wait_valid(input string tag);
    int n = 0;
    @(negedge clk);
    while (!insn_valid && n < 100) begin decide(); @(negedge clk); n++; end
    check(tag, 64'(n < 100), 64'd1);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    @(negedge clk);
    while (!mem_req && n < 100) begin decide(); @(negedge clk); n++; end
    check(tag, 64'(n < 100), 64'd1);
  endtask

  initial begin
    logic [31:0] hold_insn;
    logic [63:0] hold_pc;
    logic [31:0] c0;
    logic        rv;
    int          n, g_halt;
    bit          gv;
    logic [13:0] ga_b;
    logic [13:0] aq_b[$];
    logic [15:0] pq_b[$];

    rst_n = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; insn_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    mem_gnt_b = 1'b0; mem_rvalid_b = 1'b0; mem_rdata_b = '0; insn_ready_b = 1'b1;
    redirect_b = 1'b0; redirect_pc_b = '0; halt_b = 1'b0;
    exp_pc = 64'h100; exp_cnt = 0; halting = 1'b0;
    pend = 1'b0; pend_wait = 0; pend_addr = '0;
    lat = 1; lat_rand = 1'b0; gnt_pct = 100; rdy_pct = 100; redir_pct = 0;
    force_redir = 1'b0; force_rdy = 1'b0; force_halt = 1'b0; force_tgt = '0;
    gcount = 0; dcount = 0; last_gaddr = '0; last_dpc = '0;

    repeat (3) @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_insn_valid", insn_valid, 1'b0);
    check("rst_insn", insn, 32'd0);
    check("rst_insn_pc", insn_pc, 64'd0);
    check("rst_halted", halted, 1'b0);
    check("rst_count", count, 32'd0);
    rst_n = 1'b1;

    // Sequential fetch from RESET_PC, 1-cycle memory, decoder always ready.
    n = 0;
    while (exp_cnt < 3 && n < 60) begin step(); n++; end
    check("t1_done", 64'(n < 60), 64'd1);
    @(negedge clk);
    check("t1_count", count, 32'd3);
    check("t1_gq_size", 64'(gq.size() >= 3), 64'd1);
    if (gq.size() >= 3) begin
      check("t1_addr0", gq[0], 14'h100);
      check("t1_addr1", gq[1], 14'h104);
      check("t1_addr2", gq[2], 14'h108);
    end
    decide();

    // Decoder stalls in HOLD.
    rdy_pct = 0;
    wait_valid("t2_wait");
    hold_insn = insn; hold_pc = insn_pc; c0 = count;
    decide();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_valid", insn_valid, 1'b1);
      check("t2_insn", insn, hold_insn);
      check("t2_pc", insn_pc, hold_pc);
      check("t2_no_req", mem_req, 1'b0);
      decide();
    end
    rdy_pct = 100;
    wait_grant("t2_gnt");
    check("t2_next_addr", last_gaddr, hold_pc[13:0] + 14'd4);
    check("t2_count", count, c0 + 32'd1);

    // Redirect to an unaligned target while a slow response is outstanding.
    lat = 4;
    wait_grant("t3_gnt");
    force_redir = 1'b1; force_tgt = 64'h2003;
    step();
    wait_deliver("t3_dlv");
    check("t3_dpc", last_dpc, 64'h2000);
    check("t3_addr", last_gaddr, 14'h2000);

    // Redirect coincident with the decoder handshake.
    lat = 1; rdy_pct = 0;
    wait_valid("t4_wait");
    c0 = count;
    force_redir = 1'b1; force_tgt = 64'h3F00; force_rdy = 1'b1;
    decide();
    @(negedge clk);
    check("t4_count", count, c0);
    check("t4_valid", insn_valid, 1'b0);
    gnt_pct = 0;
    decide();
    gnt_pct = 100; rdy_pct = 100;
    wait_grant("t4_gnt");
    check("t4_addr", last_gaddr, 14'h3F00);

    // Redirect coincident with a grant.
    gnt_pct = 0;
    wait_req("t4b_req");
    gnt_pct = 100;
    force_redir = 1'b1; force_tgt = 64'h0ABC;
    decide();
    wait_deliver("t4b_dlv");
    check("t4b_dpc", last_dpc, 64'h0AB8 + 64'h4);

    // Randomized traffic with variable latency, backpressure and redirects.
    lat_rand = 1'b1; gnt_pct = 60; rdy_pct = 60; redir_pct = 4;
    repeat (1500) step();

    // Halt while waiting on a 3-cycle response.
    lat_rand = 1'b0; lat = 3; gnt_pct = 100; rdy_pct = 100; redir_pct = 0;
    wait_grant("t5_gnt");
    g_halt = gcount;
    force_halt = 1'b1;
    step();
    n = 0;
    rv = 1'b0;
    while (n < 20) begin
      rv = mem_rvalid;
      @(negedge clk);
      if (halted) break;
      decide();
      n++;
    end
    check("t5_halt_seen", 64'(n < 20), 64'd1);
    check("t5_halt_after_rsp", rv, 1'b1);
    decide();
    for (int i = 0; i < 6; i++) begin
      force_redir = 1'b1; force_tgt = 64'h500;
      @(negedge clk);
      check("t5_halted", halted, 1'b1);
      check("t5_no_req", mem_req, 1'b0);
      check("t5_no_valid", insn_valid, 1'b0);
      decide();
    end
    check("t5_no_grant", 64'(gcount), 64'(g_halt));

    // Narrow PC wraps past the top of its range.
    gv = 1'b0; ga_b = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (insn_valid_b) begin
        pq_b.push_back(insn_pc_b);
        check("t6_insn", insn_b, mem_word(insn_pc_b[13:0]));
      end
      mem_rvalid_b = gv;
      mem_rdata_b  = gv ? mem_word(ga_b) : 32'd0;
      gv           = mem_req_b;
      mem_gnt_b    = 1'b1;
      if (mem_req_b) begin
        aq_b.push_back(mem_addr_b);
        ga_b = mem_addr_b;
      end
    end
    check("t6_sizes", 64'(aq_b.size() >= 2 && pq_b.size() >= 2), 64'd1);
    if (aq_b.size() >= 2 && pq_b.size() >= 2) begin
      check("t6_addr0", aq_b[0], 14'h3FFC);
      check("t6_addr1", aq_b[1], 14'h0000);
      check("t6_pc0", pq_b[0], 16'hFFFC);
      check("t6_pc1", pq_b[1], 16'h0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
